// File: rtl/memory_dp_clr.sv
// Dual-port data memory: port A read/write with combinational read, port B registered read.
// A sequential clear engine writes CLEAR_VALUE to every word after reset or on clr_start.
module memory_dp_clr #(
    parameter int WORD_SIZE = 8,
    parameter int ADDR_SIZE = 8,
    parameter logic [WORD_SIZE-1:0] CLEAR_VALUE = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_SIZE-1:0] a_addr,
    input  logic [WORD_SIZE-1:0] a_din,
    input  logic                 a_we,
    output logic [WORD_SIZE-1:0] a_dout,
    input  logic [ADDR_SIZE-1:0] b_addr,
    input  logic                 b_re,
    output logic [WORD_SIZE-1:0] b_dout,
    output logic                 b_valid,
    input  logic                 clr_start,
    output logic                 busy
);

    localparam int DEPTH = 2 ** ADDR_SIZE;
    localparam logic [ADDR_SIZE:0] MAX_PTR = {1'b0, {ADDR_SIZE{1'b1}}};

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t                 state;
    logic [ADDR_SIZE:0]     ptr;
    logic [WORD_SIZE-1:0]   mem [DEPTH];

    // The array itself has no reset; only the clear engine initialises it.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[ptr[ADDR_SIZE-1:0]] <= CLEAR_VALUE;
        end else if (a_we) begin
            mem[a_addr] <= a_din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= CLEAR;
            ptr     <= '0;
            busy    <= 1'b1;
            b_dout  <= '0;
            b_valid <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    b_valid <= 1'b0;
                    if (ptr == MAX_PTR) begin
                        ptr   <= '0;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
                IDLE: begin
                    // Port B is serviced on the same edge that accepts clr_start.
                    b_valid <= b_re;
                    if (b_re) begin
                        b_dout <= mem[b_addr];
                    end
                    if (clr_start) begin
                        state <= CLEAR;
                        ptr   <= '0;
                        busy  <= 1'b1;
                    end
                end
                default: begin
                    state <= CLEAR;
                    ptr   <= '0;
                    busy  <= 1'b1;
                end
            endcase
        end
    end

    assign a_dout = busy ? CLEAR_VALUE : mem[a_addr];

endmodule

// File: doc/memory_dp_clr.md
Name: memory_dp_clr

Overview:
Parametrised successor to the single-port, combinational-read data memory. It has two ports:
- Port A: read/write, combinational read.
- Port B: read-only, registered one-cycle read with a valid strobe.
Array clearing is done by a sequential clear engine, one word per cycle, started after reset or on command. This replaces the single-cycle flush of the whole array. It is the CPU data/instruction store, and port B serves a debug/fetch path.

Parameters:
WORD_SIZE, 8, data word width in bits (1..64)
ADDR_SIZE, 8, address width in bits (1..16); depth DEPTH = 2**ADDR_SIZE, MAX_ADDR = DEPTH-1
CLEAR_VALUE, 0, word value written by the clear engine (WORD_SIZE bits)

Ports:
clk  in  1  clock, all state changes on rising edge
rst  in  1  reset, asynchronous, active-high
a_addr  in  ADDR_SIZE  port A address
a_din  in  WORD_SIZE  port A write data
a_we  in  1  port A write enable
a_dout  out  WORD_SIZE  port A read data, combinational from a_addr
b_addr  in  ADDR_SIZE  port B read address
b_re  in  1  port B read request
b_dout  out  WORD_SIZE  port B registered read data
b_valid  out  1  b_dout holds data for the request accepted on the previous edge
clr_start  in  1  request a full-array clear
busy  out  1  clear engine active; array not accessible

Behaviour:
- Clock and reset: reset rst, asynchronous, active-high; clock clk.
- Reset values: FSM=CLEAR, clear pointer=0, busy=1, b_dout=0, b_valid=0.
- Array contents are not reset directly. Reset only starts the clear engine.
- FSM has two states, IDLE and CLEAR.
- CLEAR state:
  - Each rising edge writes CLEAR_VALUE to array[ptr], then ptr increments.
  - On the edge that writes MAX_ADDR, ptr wraps to 0 and the FSM moves to IDLE. busy falls after that edge.
  - After rst deasserts, busy stays high for exactly DEPTH rising edges.
- IDLE state: clr_start=1 sampled on edge N moves the FSM to CLEAR with ptr=0.
  - busy=1 after edge N.
  - Words are cleared on edges N+1 .. N+DEPTH.
  - busy=0 after edge N+DEPTH.
- clr_start while busy is ignored. The clear does not restart or extend.
- rst asserted mid-clear immediately returns ptr to 0. The full clear sequence restarts after release.
- While busy:
  - a_we is ignored and no write occurs.
  - a_dout is driven to CLEAR_VALUE.
  - b_re is ignored, so b_valid=0 on the following cycle.
- Port A, when not busy:
  - a_dout = array[a_addr], combinational.
  - a_we=1 writes a_din to array[a_addr] at the edge.
  - During the write cycle a_dout shows the old value. The new value is visible after the edge.
- Port B, when not busy:
  - b_re=1 at edge N loads b_dout from array[b_addr] as it was before edge N, and b_valid=1 after edge N.
  - b_re=0 at edge N sets b_valid=0 after edge N. b_dout holds its last value.
- Port A write and port B read to the same address on the same edge: B returns the old data (read-before-write). The next B read returns the new data.
- Port B read on the same edge that busy falls: b_re is ignored, because busy=1 at that edge. Port B is usable from the following edge.
- All address arithmetic is unsigned. ptr is ADDR_SIZE+1 bits internally so the terminal count MAX_ADDR is detected without overflow.
- No X propagation to outputs after the first completed clear.

Test Plan:
- Reset clear: WORD_SIZE=8, ADDR_SIZE=4, CLEAR_VALUE=0. Pulse rst, then count cycles -> busy=1 for exactly 16 edges then 0. Afterwards, reading all 16 addresses on A and on B returns 0x00.
- Write/read: write 0xA5 to addr 3 via A, then b_re addr 3 -> a_dout=0xA5 after the write edge; b_dout=0xA5 with b_valid=1 one cycle after the b_re edge.
- Collision: array[7]=0x11. Same edge: a_we addr 7 data 0x22 and b_re addr 7 -> b_dout=0x11. The next b_re addr 7 gives 0x22.
- Command clear: fill memory with 0xFF, pulse clr_start one cycle -> busy=1 for 16 edges. a_we during busy has no effect, b_re during busy gives b_valid=0. Afterwards all words read 0x00.
- Reset mid-clear: assert clr_start, then assert rst after 5 clear edges and release -> busy remains high for a full 16 edges after release. A second clr_start during busy does not lengthen it.
- Parameter sweep: WORD_SIZE=16, ADDR_SIZE=1, CLEAR_VALUE=0xBEEF -> busy for 2 edges; both words read 0xBEEF; writes to addr 0 and 1 read back independently.
